// File: rtl/ic_tile_2way.sv
// Two-way set-associative instruction cache tile. Returns a 96-bit fetch
// window at any halfword-aligned PC, filling the two lines it spans from the memory port.
module ic_tile_2way #(
    parameter int IDX_BITS  = 8,
    parameter int ADDR_BITS = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  regInPc,
    input  logic         icFlush,
    output logic [95:0]  regOutPcVal,
    output logic [1:0]   regOutPcOK,
    output logic [63:0]  memPcAddr,
    output logic         memPcOE,
    input  logic [127:0] memPcData,
    input  logic [1:0]   memPcOK
);

    localparam int SETS = 2 ** IDX_BITS;
    localparam int LW   = ADDR_BITS - 4;
    localparam int TW   = LW - IDX_BITS;

    localparam logic [1:0] UMEM_OK_READY = 2'd0;
    localparam logic [1:0] UMEM_OK_OK    = 2'd1;
    localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

    typedef enum logic [1:0] {
        StFlush = 2'd0,
        StIdle  = 2'd1,
        StReq   = 2'd2,
        StFault = 2'd3
    } IcState;

    IcState state, stateNext;
    logic [IDX_BITS-1:0] flushIdx, flushIdxNext;
    logic [LW-1:0]       reqLine, reqLineNext;

    logic [127:0]   dataWay0 [SETS];
    logic [127:0]   dataWay1 [SETS];
    logic [TW-1:0]  tagWay0  [SETS];
    logic [TW-1:0]  tagWay1  [SETS];
    logic [SETS-1:0] validWay0, validWay1, lruBits;

    logic [LW-1:0]       lineA, lineB, missLine;
    logic [IDX_BITS-1:0] idxA, idxB, reqIdx;
    logic [TW-1:0]       tagA, tagB, reqTag;
    logic hitA0, hitA1, hitB0, hitB1, hitA, hitB, needB;
    logic lookupHit, onFaultLine, fillNow, fillWay;
    logic [127:0] lineAData, lineBData;
    logic [255:0] windowPair;
    logic unusedPcBits;

    assign unusedPcBits = ^{regInPc[63:ADDR_BITS], regInPc[0]};

    assign lineA = regInPc[ADDR_BITS-1:4];
    assign lineB = lineA + {{(LW-1){1'b0}}, 1'b1};
    assign idxA  = lineA[IDX_BITS-1:0];
    assign idxB  = lineB[IDX_BITS-1:0];
    assign tagA  = lineA[LW-1:IDX_BITS];
    assign tagB  = lineB[LW-1:IDX_BITS];
    assign reqIdx = reqLine[IDX_BITS-1:0];
    assign reqTag = reqLine[LW-1:IDX_BITS];

    assign hitA0 = validWay0[idxA] && (tagWay0[idxA] == tagA);
    assign hitA1 = validWay1[idxA] && (tagWay1[idxA] == tagA);
    assign hitB0 = validWay0[idxB] && (tagWay0[idxB] == tagB);
    assign hitB1 = validWay1[idxB] && (tagWay1[idxB] == tagB);
    assign hitA  = hitA0 || hitA1;
    assign hitB  = hitB0 || hitB1;

    // Offsets 0..2 halfwords keep all six halfwords inside line A.
    assign needB     = regInPc[3:1] > 3'd2;
    assign lookupHit = (state != StFlush) && hitA && (!needB || hitB);
    assign missLine  = hitA ? lineB : lineA;
    assign onFaultLine = (lineA == reqLine) || (needB && (lineB == reqLine));

    assign fillWay = lruBits[reqIdx];
    assign fillNow = (state == StReq) && (memPcOK == UMEM_OK_OK) && !icFlush && !reset;

    assign lineAData  = hitA1 ? dataWay1[idxA] : dataWay0[idxA];
    assign lineBData  = hitB1 ? dataWay1[idxB] : dataWay0[idxB];
    assign windowPair = {lineBData, lineAData};

    // Fetch response: fault report has priority over a (stale) hit.
    always_comb begin
        regOutPcOK  = UMEM_OK_READY;
        regOutPcVal = 96'd0;
        if ((state == StFault) && onFaultLine) begin
            regOutPcOK = UMEM_OK_FAULT;
        end else if (lookupHit) begin
            regOutPcOK  = UMEM_OK_OK;
            regOutPcVal = windowPair[{regInPc[3:1], 4'b0000} +: 96];
        end else begin
            regOutPcOK  = UMEM_OK_READY;
            regOutPcVal = 96'd0;
        end
    end

    // Memory request port, only active while a fill is outstanding.
    always_comb begin
        memPcOE   = 1'b0;
        memPcAddr = 64'd0;
        if (state == StReq) begin
            memPcOE   = 1'b1;
            memPcAddr = {{(64-ADDR_BITS){1'b0}}, reqLine, 4'b0000};
        end else begin
            memPcOE   = 1'b0;
            memPcAddr = 64'd0;
        end
    end

    // Next-state logic; a flush request overrides every state.
    always_comb begin
        stateNext    = state;
        flushIdxNext = flushIdx;
        reqLineNext  = reqLine;
        if (icFlush) begin
            stateNext    = StFlush;
            flushIdxNext = {IDX_BITS{1'b0}};
        end else begin
            case (state)
                StFlush: begin
                    if (&flushIdx) begin
                        stateNext = StIdle;
                    end else begin
                        flushIdxNext = flushIdx + {{(IDX_BITS-1){1'b0}}, 1'b1};
                    end
                end
                StIdle: begin
                    if (!lookupHit) begin
                        stateNext   = StReq;
                        reqLineNext = missLine;
                    end else begin
                        stateNext = StIdle;
                    end
                end
                StReq: begin
                    case (memPcOK)
                        UMEM_OK_OK:    stateNext = StIdle;
                        UMEM_OK_FAULT: stateNext = StFault;
                        default:       stateNext = StReq;
                    endcase
                end
                StFault: begin
                    if (!onFaultLine) begin
                        stateNext = StIdle;
                    end else begin
                        stateNext = StFault;
                    end
                end
                default: stateNext = StFlush;
            endcase
        end
    end

    // Control state and LRU bits; a fill's LRU write wins over a same-set hit update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= StFlush;
            flushIdx <= {IDX_BITS{1'b0}};
            reqLine  <= {LW{1'b0}};
            lruBits  <= {SETS{1'b0}};
        end else begin
            state    <= stateNext;
            flushIdx <= flushIdxNext;
            reqLine  <= reqLineNext;
            if (lookupHit) begin
                lruBits[idxA] <= hitA0;
                if (needB) begin
                    lruBits[idxB] <= hitB0;
                end
            end
            if (fillNow) begin
                lruBits[reqIdx] <= ~fillWay;
            end
        end
    end

    // Valid bits: swept clear during flush, set by a fill.
    always_ff @(posedge clock) begin
        if (state == StFlush) begin
            validWay0[flushIdx] <= 1'b0;
            validWay1[flushIdx] <= 1'b0;
        end else if (fillNow) begin
            if (fillWay) begin
                validWay1[reqIdx] <= 1'b1;
            end else begin
                validWay0[reqIdx] <= 1'b1;
            end
        end
    end

    // Way 0 data/tag array.
    always_ff @(posedge clock) begin
        if (fillNow && !fillWay) begin
            dataWay0[reqIdx] <= memPcData;
            tagWay0[reqIdx]  <= reqTag;
        end
    end

    // Way 1 data/tag array.
    always_ff @(posedge clock) begin
        if (fillNow && fillWay) begin
            dataWay1[reqIdx] <= memPcData;
            tagWay1[reqIdx]  <= reqTag;
        end
    end

endmodule
